// File: rtl/ftoi_pipe.sv
// IEEE-754 single to int32 converter: round half away from zero, saturating, NSTAGE-deep valid/ready pipe.
// Define FTOI_FLAG_EN to add the ovf output that marks saturated results.
module ftoi_pipe #(
  parameter int NSTAGE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
`ifdef FTOI_FLAG_EN
  ,
  output logic        ovf
`endif
);
  typedef enum logic [1:0] {CLS_ZERO, CLS_HALF, CLS_NORM, CLS_SAT} cls_e;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic        f_s;
  logic [7:0]  f_e;
  cls_e        f_cls;
  logic [53:0] f_wide;
  logic [30:0] f_mag;
  logic        f_g;
  logic [21:0] unused_frac;

  // Align the integer point at bit 23 of f_wide; the bit just below it is the guard bit.
  always_comb begin
    f_s         = x[31];
    f_e         = x[30:23];
    f_wide      = {30'd0, 1'b1, x[22:0]} << (f_e - 8'd127);
    f_mag       = f_wide[53:23];
    f_g         = f_wide[22];
    unused_frac = f_wide[21:0];
    if (f_e <= 8'd125)      f_cls = CLS_ZERO;
    else if (f_e == 8'd126) f_cls = CLS_HALF;
    else if (f_e <= 8'd157) f_cls = CLS_NORM;
    else                    f_cls = CLS_SAT;
  end

`ifdef FTOI_FLAG_EN
  logic f_ovf;
  logic b_ovf;
  // -2^31 saturates to the same code but is exact, so it is not an overflow.
  assign f_ovf = (f_cls == CLS_SAT) && (x != 32'hCF00_0000);
`endif

  logic        b_vld;
  logic        b_s;
  cls_e        b_cls;
  logic [30:0] b_mag;
  logic        b_g;

  if (NSTAGE == 2) begin : g_s2
    logic        s1_vld_q;
    logic        s1_s_q;
    cls_e        s1_cls_q;
    logic [30:0] s1_mag_q;
    logic        s1_g_q;
`ifdef FTOI_FLAG_EN
    logic        s1_ovf_q;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_vld_q <= 1'b0;
        s1_s_q   <= 1'b0;
        s1_cls_q <= CLS_ZERO;
        s1_mag_q <= '0;
        s1_g_q   <= 1'b0;
`ifdef FTOI_FLAG_EN
        s1_ovf_q <= 1'b0;
`endif
      end else if (adv) begin
        s1_vld_q <= in_valid;
        s1_s_q   <= f_s;
        s1_cls_q <= f_cls;
        s1_mag_q <= f_mag;
        s1_g_q   <= f_g;
`ifdef FTOI_FLAG_EN
        s1_ovf_q <= f_ovf;
`endif
      end
    end

    assign b_vld = s1_vld_q;
    assign b_s   = s1_s_q;
    assign b_cls = s1_cls_q;
    assign b_mag = s1_mag_q;
    assign b_g   = s1_g_q;
`ifdef FTOI_FLAG_EN
    assign b_ovf = s1_ovf_q;
`endif
  end else begin : g_s1
    assign b_vld = in_valid;
    assign b_s   = f_s;
    assign b_cls = f_cls;
    assign b_mag = f_mag;
    assign b_g   = f_g;
`ifdef FTOI_FLAG_EN
    assign b_ovf = f_ovf;
`endif
  end

  logic [31:0] b_r;
  logic [31:0] y_d;

  always_comb begin
    b_r = {1'b0, b_mag} + {31'd0, b_g};
    case (b_cls)
      CLS_ZERO: y_d = 32'd0;
      CLS_HALF: y_d = b_s ? 32'hFFFF_FFFF : 32'd1;
      CLS_NORM: y_d = b_s ? (32'd0 - b_r) : b_r;
      default:  y_d = b_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endcase
  end

  logic        out_valid_q;
  logic [31:0] y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else if (adv) begin
      out_valid_q <= b_vld;
      y_q         <= y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;

`ifdef FTOI_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst)      ovf_q <= 1'b0;
    else if (adv) ovf_q <= b_ovf;
  end

  assign ovf = ovf_q;
`endif

endmodule
